frame_scheduler: RTL and testbench

FRAME_SCHEDULER -- requirements
Module: frame_scheduler

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/frame_scheduler_if.sv | 28 ++
 rtl/flash_sequencer.sv | 119 +++++++++++
 rtl/frame_scheduler.sv | 78 +++++++
 tb/tb_frame_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/tetris_pkg.sv
// Shared field geometry and scheduler state encoding for the Tetris display path.
package tetris_pkg;

    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int CELLS = COLS * ROWS;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        FLASH_ON  = 3'd2,
        FLASH_OFF = 3'd3,
        DONE      = 3'd4
    } sched_state_t;

    // Spread one bit per block row across all ten cells of that row.
    function automatic logic [CELLS-1:0] expand_rows(input logic [ROWS-1:0] rows);
        logic [CELLS-1:0] mask;
        mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            mask[r*COLS +: COLS] = {COLS{rows[r]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Bundle of the game-logic and display signals around the frame scheduler.
interface frame_scheduler_if;
    import tetris_pkg::*;

    logic             vs;
    logic [CELLS-1:0] matrix_in;
    logic             matrix_wr;
    logic             clear_req;
    logic [ROWS-1:0]  clear_rows;
    logic             fail;
    logic             clear_ack;
    logic             clear_done;
    logic             busy;
    logic             frame_tick;
    logic [CELLS-1:0] matrix_out;
    logic [CELLS-1:0] flash_mask;

    modport master (
        output vs, matrix_in, matrix_wr, clear_req, clear_rows, fail,
        input  clear_ack, clear_done, busy, frame_tick, matrix_out, flash_mask
    );

    modport slave (
        input  vs, matrix_in, matrix_wr, clear_req, clear_rows, fail,
        output clear_ack, clear_done, busy, frame_tick, matrix_out, flash_mask
    );

endinterface

// File: rtl/flash_sequencer.sv
// Row-clear animation: accepts a clear request, alternates flash on/off every
// FLASH_FRAMES frames for FLASH_PHASES phases, then reports completion.
module flash_sequencer
    import tetris_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PHASES = 6
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             tick,
    input  logic             clear_req,
    input  logic [ROWS-1:0]  clear_rows,
    input  logic             fail,
    output logic             clear_ack,
    output logic             clear_done,
    output logic             busy,
    output logic [CELLS-1:0] flash_mask
);

    localparam logic [3:0] FRAME_LAST = 4'(FLASH_FRAMES - 1);
    localparam logic [3:0] PHASE_LAST = 4'(FLASH_PHASES - 1);

    sched_state_t    state_q, state_d;
    logic [3:0]      frame_cnt_q, frame_cnt_d;
    logic [3:0]      phase_cnt_q, phase_cnt_d;
    logic [ROWS-1:0] rows_q, rows_d;
    logic            accept;

    // State, counters and latched rows.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            phase_cnt_q <= '0;
            rows_q      <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            rows_q      <= rows_d;
        end
    end

    // Next-state, counter and accept decode.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        phase_cnt_d = phase_cnt_q;
        rows_d      = rows_q;
        accept      = 1'b0;

        unique case (state_q)
            IDLE: begin
                frame_cnt_d = '0;
                phase_cnt_d = '0;
                if (clear_req && !fail) begin
                    accept  = 1'b1;
                    rows_d  = clear_rows;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (rows_q == '0) begin
                    state_d = DONE;
                end else if (tick) begin
                    state_d = FLASH_ON;
                end
            end
            FLASH_ON, FLASH_OFF: begin
                if (tick) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        frame_cnt_d = '0;
                        if (phase_cnt_q == PHASE_LAST) begin
                            phase_cnt_d = '0;
                            state_d     = DONE;
                        end else begin
                            phase_cnt_d = phase_cnt_q + 4'd1;
                            state_d     = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Game over aborts any animation in progress without completing it.
        if (fail && state_q != IDLE) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
            phase_cnt_d = '0;
        end
    end

    // Registered handshake pulses and flash mask, aligned to the state they describe.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clear_ack  <= 1'b0;
            clear_done <= 1'b0;
            flash_mask <= '0;
        end else begin
            clear_ack  <= accept;
            clear_done <= (state_q == DONE) && !fail;
            flash_mask <= (state_d == FLASH_ON) ? expand_rows(rows_q) : '0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: vsync edge detection, tear-free double buffering of the
// game field, and the row-clear flash animation.
module frame_scheduler
    import tetris_pkg::*;
#(
    parameter int FLASH_FRAMES = 8,
    parameter int FLASH_PHASES = 6
) (
    input  logic              clk,
    input  logic              clrn,
    frame_scheduler_if.slave  bus
);

    logic             vs_q;
    logic             frame_edge;
    logic             frame_tick_q;
    logic             dirty;
    logic [CELLS-1:0] pending;
    logic [CELLS-1:0] matrix_q;

    // vs is already in the pixel clock domain, so one register suffices for edge detection.
    assign frame_edge = vs_q & ~bus.vs;

    // Registered vsync and one-cycle frame tick on each falling edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            vs_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            vs_q         <= bus.vs;
            frame_tick_q <= frame_edge;
        end
    end

    // Double buffer: writes land in pending, the display copy only moves on a frame edge.
    // NOTE: the field buffers are plain flops, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pending  <= '0;
            matrix_q <= '0;
            dirty    <= 1'b0;
        end else begin
            if (bus.matrix_wr) begin
                pending <= bus.matrix_in;
            end
            if (frame_edge) begin
                if (bus.matrix_wr) begin
                    matrix_q <= bus.matrix_in;
                end else if (dirty) begin
                    matrix_q <= pending;
                end
                dirty <= 1'b0;
            end else if (bus.matrix_wr) begin
                dirty <= 1'b1;
            end
        end
    end

    assign bus.frame_tick = frame_tick_q;
    assign bus.matrix_out = matrix_q;

    flash_sequencer #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .FLASH_PHASES (FLASH_PHASES)
    ) u_flash_sequencer (
        .clk        (clk),
        .clrn       (clrn),
        .tick       (frame_edge),
        .clear_req  (bus.clear_req),
        .clear_rows (bus.clear_rows),
        .fail       (bus.fail),
        .clear_ack  (bus.clear_ack),
        .clear_done (bus.clear_done),
        .busy       (bus.busy),
        .flash_mask (bus.flash_mask)
    );

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler with FLASH_FRAMES=2, FLASH_PHASES=2.
module tb_frame_scheduler;

    logic clk;
    logic clrn;
    int   n_asserts;
    int   n_failures;

    frame_scheduler_if bus ();

    frame_scheduler #(
        .FLASH_FRAMES (2),
        .FLASH_PHASES (2)
    ) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    // 25 MHz pixel clock.
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Absolute time bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_fall();
        bus.vs = 1'b0;
        step();
    endtask

    task automatic vs_rise();
        bus.vs = 1'b1;
        step();
        step();
    endtask

    task automatic check(input string tag, input logic [199:0] observed, input logic [199:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_failures++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    logic [199:0] pat_a, pat_b, pat_c;
    logic [199:0] mask_rows_0_19, mask_row_2, mask_row_4;

    initial begin
        n_asserts  = 0;
        n_failures = 0;
        pat_a = {50{4'hA}};
        pat_b = {50{4'h5}};
        pat_c = {25{8'h3C}};
        mask_rows_0_19 = '0;
        mask_rows_0_19[9:0]     = '1;
        mask_rows_0_19[199:190] = '1;
        mask_row_2 = '0;
        mask_row_2[29:20] = '1;
        mask_row_4 = '0;
        mask_row_4[49:40] = '1;

        clrn           = 1'b0;
        bus.vs         = 1'b1;
        bus.matrix_in  = '0;
        bus.matrix_wr  = 1'b0;
        bus.clear_req  = 1'b0;
        bus.clear_rows = '0;
        bus.fail       = 1'b0;

        // Reset state.
        step();
        step();
        check("rst_matrix_out", bus.matrix_out, '0);
        check("rst_flash_mask", bus.flash_mask, '0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_tick", bus.frame_tick, 0);
        check("rst_clear_ack", bus.clear_ack, 0);
        check("rst_clear_done", bus.clear_done, 0);
        clrn = 1'b1;
        step();

        // Two writes in one frame: only the last is shown, and only on the frame tick.
        bus.matrix_in = pat_a;
        bus.matrix_wr = 1'b1;
        step();
        bus.matrix_in = pat_b;
        step();
        bus.matrix_wr = 1'b0;
        step();
        check("dbuf_before_edge", bus.matrix_out, '0);
        check("dbuf_no_tick", bus.frame_tick, 0);
        vs_fall();
        check("dbuf_tick", bus.frame_tick, 1);
        check("dbuf_last_write", bus.matrix_out, pat_b);
        step();
        check("tick_once_per_frame", bus.frame_tick, 0);
        check("dbuf_hold", bus.matrix_out, pat_b);
        vs_rise();

        // Write coincident with the frame edge goes straight to the display.
        bus.vs        = 1'b0;
        bus.matrix_in = pat_c;
        bus.matrix_wr = 1'b1;
        step();
        bus.matrix_wr = 1'b0;
        check("coinc_tick", bus.frame_tick, 1);
        check("coinc_matrix_out", bus.matrix_out, pat_c);
        vs_rise();
        vs_fall();
        check("coinc_next_tick", bus.frame_tick, 1);
        check("coinc_next_unchanged", bus.matrix_out, pat_c);
        vs_rise();

        // Rows 0 and 19 flash for 2 frames on, 2 frames off.
        bus.clear_rows = 20'h80001;
        bus.clear_req  = 1'b1;
        step();
        check("flash_ack", bus.clear_ack, 1);
        check("flash_busy_arm", bus.busy, 1);
        check("flash_mask_arm", bus.flash_mask, '0);
        step();
        check("flash_ack_once", bus.clear_ack, 0);
        vs_fall();
        check("flash_on_t0", bus.flash_mask, mask_rows_0_19);
        check("flash_req_ignored", bus.clear_ack, 0);
        bus.clear_req = 1'b0;
        vs_rise();
        check("flash_on_hold", bus.flash_mask, mask_rows_0_19);
        vs_fall();
        check("flash_on_t1", bus.flash_mask, mask_rows_0_19);
        vs_rise();
        vs_fall();
        check("flash_off_t2", bus.flash_mask, '0);
        check("flash_busy_off", bus.busy, 1);
        vs_rise();
        vs_fall();
        check("flash_off_t3", bus.flash_mask, '0);
        check("flash_not_done_t3", bus.clear_done, 0);
        vs_rise();
        vs_fall();
        check("flash_done_state_busy", bus.busy, 1);
        check("flash_done_not_yet", bus.clear_done, 0);
        bus.vs = 1'b1;
        step();
        check("flash_clear_done", bus.clear_done, 1);
        check("flash_idle_busy", bus.busy, 0);
        step();
        check("flash_done_once", bus.clear_done, 0);

        // Empty row set finishes without flashing.
        bus.clear_rows = 20'h00000;
        bus.clear_req  = 1'b1;
        step();
        bus.clear_req = 1'b0;
        check("empty_ack", bus.clear_ack, 1);
        step();
        check("empty_done_early", bus.clear_done, 0);
        check("empty_mask_1", bus.flash_mask, '0);
        step();
        check("empty_done", bus.clear_done, 1);
        check("empty_mask_2", bus.flash_mask, '0);
        check("empty_busy", bus.busy, 0);
        step();

        // Game over during FLASH_ON aborts without completion.
        bus.clear_rows = 20'h00004;
        bus.clear_req  = 1'b1;
        step();
        bus.clear_req = 1'b0;
        check("fail_ack", bus.clear_ack, 1);
        vs_fall();
        check("fail_flash_on", bus.flash_mask, mask_row_2);
        bus.fail = 1'b1;
        step();
        check("fail_busy", bus.busy, 0);
        check("fail_mask", bus.flash_mask, '0);
        bus.fail = 1'b0;
        bus.vs   = 1'b1;
        step();
        check("fail_no_done_1", bus.clear_done, 0);
        step();
        check("fail_no_done_2", bus.clear_done, 0);

        // Asynchronous reset in the middle of a flash, then a fresh request.
        bus.clear_rows = 20'h00010;
        bus.clear_req  = 1'b1;
        step();
        bus.clear_req = 1'b0;
        check("rst2_ack", bus.clear_ack, 1);
        vs_fall();
        check("rst2_flash_on", bus.flash_mask, mask_row_4);
        check("rst2_tick_before", bus.frame_tick, 1);
        clrn = 1'b0;
        #5;
        check("rst2_mask", bus.flash_mask, '0);
        check("rst2_matrix_out", bus.matrix_out, '0);
        check("rst2_busy", bus.busy, 0);
        check("rst2_tick", bus.frame_tick, 0);
        check("rst2_ack_low", bus.clear_ack, 0);
        bus.vs = 1'b1;
        step();
        clrn = 1'b1;
        step();
        check("rst2_idle", bus.busy, 0);
        check("rst2_no_done", bus.clear_done, 0);
        bus.clear_rows = 20'h00001;
        bus.clear_req  = 1'b1;
        step();
        bus.clear_req = 1'b0;
        check("rst2_reack", bus.clear_ack, 1);
        check("rst2_rebusy", bus.busy, 1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
        $finish;
    end

endmodule
